// File: rtl/mips_cpu_harvard.sv
`default_nettype none
// mips_cpu_harvard: single-cycle MIPS-I subset core with Harvard buses.
// Optional delay slot: define MIPS_BRANCH_DELAY_SLOT_EN. Rev 1.0
module mips_cpu_harvard #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  logic [31:0] pc_q, pc_d;
  logic        active_q, active_d;
  logic [31:0] regs_q [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val, imm_s, imm_z, pc_plus4, br_tgt, link;
  logic        wen, taken, is_lw, is_sw, advance;
  logic [4:0]  waddr;
  logic [31:0] wdata, target;

  assign op     = instr_readdata[31:26];
  assign rs     = instr_readdata[25:21];
  assign rt     = instr_readdata[20:16];
  assign rd     = instr_readdata[15:11];
  assign shamt  = instr_readdata[10:6];
  assign funct  = instr_readdata[5:0];
  assign imm    = instr_readdata[15:0];

  // $0 is never written, so a plain array read already returns zero for it.
  assign rs_val   = regs_q[rs];
  assign rt_val   = regs_q[rt];
  assign imm_s    = {{16{imm[15]}}, imm};
  assign imm_z    = {16'h0000, imm};
  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_plus4 + {imm_s[29:0], 2'b00};
  assign advance  = clk_enable & active_q;

  always_comb begin
    wen    = 1'b0;
    waddr  = rt;
    wdata  = 32'h0;
    taken  = 1'b0;
    target = pc_plus4;
    is_lw  = 1'b0;
    is_sw  = 1'b0;
    case (op)
      OP_SPECIAL: begin
        waddr = rd;
        case (funct)
          FN_SLL:  begin wen = 1'b1; wdata = rt_val << shamt; end
          FN_SRL:  begin wen = 1'b1; wdata = rt_val >> shamt; end
          FN_SRA:  begin wen = 1'b1; wdata = $unsigned($signed(rt_val) >>> shamt); end
          FN_SLLV: begin wen = 1'b1; wdata = rt_val << rs_val[4:0]; end
          FN_SRLV: begin wen = 1'b1; wdata = rt_val >> rs_val[4:0]; end
          FN_SRAV: begin wen = 1'b1; wdata = $unsigned($signed(rt_val) >>> rs_val[4:0]); end
          FN_JR:   begin taken = 1'b1; target = rs_val; end
          FN_JALR: begin taken = 1'b1; target = rs_val; wen = 1'b1; wdata = link; end
          FN_ADDU: begin wen = 1'b1; wdata = rs_val + rt_val; end
          FN_SUBU: begin wen = 1'b1; wdata = rs_val - rt_val; end
          FN_AND:  begin wen = 1'b1; wdata = rs_val & rt_val; end
          FN_OR:   begin wen = 1'b1; wdata = rs_val | rt_val; end
          FN_XOR:  begin wen = 1'b1; wdata = rs_val ^ rt_val; end
          FN_SLT:  begin wen = 1'b1; wdata = {31'h0, $signed(rs_val) < $signed(rt_val)}; end
          FN_SLTU: begin wen = 1'b1; wdata = {31'h0, rs_val < rt_val}; end
          default: ;
        endcase
      end
      OP_REGIMM: begin
        target = br_tgt;
        if (rt == 5'd0)      taken = rs_val[31];
        else if (rt == 5'd1) taken = ~rs_val[31];
      end
      OP_J:   begin taken = 1'b1; target = {pc_q[31:28], instr_readdata[25:0], 2'b00}; end
      OP_JAL: begin
        taken  = 1'b1;
        target = {pc_q[31:28], instr_readdata[25:0], 2'b00};
        wen    = 1'b1;
        waddr  = 5'd31;
        wdata  = link;
      end
      OP_BEQ:   begin target = br_tgt; taken = (rs_val == rt_val); end
      OP_BNE:   begin target = br_tgt; taken = (rs_val != rt_val); end
      OP_BLEZ:  begin target = br_tgt; taken = rs_val[31] | (rs_val == 32'h0); end
      OP_BGTZ:  begin target = br_tgt; taken = ~rs_val[31] & (rs_val != 32'h0); end
      OP_ADDIU: begin wen = 1'b1; wdata = rs_val + imm_s; end
      OP_SLTI:  begin wen = 1'b1; wdata = {31'h0, $signed(rs_val) < $signed(imm_s)}; end
      OP_SLTIU: begin wen = 1'b1; wdata = {31'h0, rs_val < imm_s}; end
      OP_ANDI:  begin wen = 1'b1; wdata = rs_val & imm_z; end
      OP_ORI:   begin wen = 1'b1; wdata = rs_val | imm_z; end
      OP_XORI:  begin wen = 1'b1; wdata = rs_val ^ imm_z; end
      OP_LUI:   begin wen = 1'b1; wdata = {imm, 16'h0000}; end
      OP_LW:    begin is_lw = 1'b1; wen = 1'b1; wdata = data_readdata; end
      OP_SW:    is_sw = 1'b1;
      default: ;
    endcase
  end

`ifdef MIPS_BRANCH_DELAY_SLOT_EN
  logic        slot_q, slot_d;
  logic [31:0] slot_tgt_q, slot_tgt_d;

  // A branch sitting in a delay slot is architecturally undefined; it is ignored here.
  always_comb begin
    slot_d     = taken & ~slot_q;
    slot_tgt_d = target;
    pc_d       = slot_q ? slot_tgt_q : pc_plus4;
  end
  assign link = pc_q + 32'd8;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q     <= 1'b0;
      slot_tgt_q <= 32'h0;
    end else if (advance) begin
      slot_q     <= slot_d;
      slot_tgt_q <= slot_tgt_d;
    end
  end
`else
  assign pc_d = taken ? target : pc_plus4;
  assign link = pc_plus4;
`endif

  assign active_d = (pc_d != 32'h0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_VECTOR;
      active_q <= 1'b1;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
    end else if (advance) begin
      pc_q     <= pc_d;
      active_q <= active_d;
      if (wen && (waddr != 5'd0)) regs_q[waddr] <= wdata;
    end
  end

  assign active         = active_q;
  assign register_v0    = regs_q[2];
  assign instr_address  = pc_q;
  assign data_address   = rs_val + imm_s;
  assign data_writedata = rt_val;
  assign data_read      = is_lw & active_q & ~reset;
  assign data_write     = is_sw & active_q & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_harvard.sv
`default_nettype none
// tb_mips_cpu_harvard: scoreboard bench for mips_cpu_harvard (default build, no delay slot).
module tb_mips_cpu_harvard;

  logic        clk = 1'b0;
  logic        reset, clk_enable, active, data_write, data_read;
  logic [31:0] register_v0, instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;

  always #5 clk = ~clk;

  mips_cpu_harvard dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .clk_enable(clk_enable), .instr_address(instr_address), .instr_readdata(instr_readdata),
    .data_address(data_address), .data_write(data_write), .data_read(data_read),
    .data_writedata(data_writedata), .data_readdata(data_readdata)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] v0;
    logic        act;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] mpc, mv0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  task automatic apply(input logic [31:0] ins, input logic [31:0] rdata);
    instr_readdata = ins;
    data_readdata  = rdata;
    #1;
  endtask

  // Push the expected architectural state, take one edge, then pop and compare.
  task automatic commit(input string tag, input logic [31:0] epc, input logic [31:0] ev0,
                        input logic eact);
    exp_t e;
    e.pc = epc; e.v0 = ev0; e.act = eact;
    sb_q.push_back(e);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    check_eq({tag, ".pc"},  instr_address,     e.pc);
    check_eq({tag, ".v0"},  register_v0,       e.v0);
    check_eq({tag, ".act"}, {31'h0, active},   {31'h0, e.act});
    mpc = epc;
    mv0 = ev0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] imm;
    reset          = 1'b1;
    clk_enable     = 1'b1;
    instr_readdata = enc_i(6'h23, 5'd0, 5'd2, 16'h0008);
    data_readdata  = 32'hDEADBEEF;
    @(posedge clk); #1;
    check_eq("rst.dread", {31'h0, data_read}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("rst.pc",  instr_address,   32'hBFC00000);
    check_eq("rst.act", {31'h0, active}, 32'h1);
    check_eq("rst.v0",  register_v0,     32'h0);
    mpc = 32'hBFC00000;
    mv0 = 32'h0;

    // LW $0,8($0): load is visible on the bus but $0 stays zero
    apply(enc_i(6'h23, 5'd0, 5'd0, 16'h0008), 32'hDEADBEEF);
    check_eq("lw0.dread",  {31'h0, data_read},  32'h1);
    check_eq("lw0.dwrite", {31'h0, data_write}, 32'h0);
    check_eq("lw0.daddr",  data_address,        32'h8);
    commit("lw0", mpc + 32'd4, 32'h0, 1'b1);

    for (int i = 2; i < 32; i++) begin
      imm = 16'(i * 32'h1111);
      apply(enc_i(6'h01, i[4:0], 5'd1, imm), 32'h0);
      commit($sformatf("bgez%0d", i), mpc + 32'd4 + {{14{imm[15]}}, imm, 2'b00}, mv0, 1'b1);
    end

    for (int i = 2; i < 32; i++) begin
      apply(enc_i(6'h23, 5'd0, i[4:0], 16'h0000), 32'h12345678);
      commit($sformatf("lw%0d", i), mpc + 32'd4, 32'h12345678, 1'b1);
    end

    apply(enc_i(6'h0F, 5'd0, 5'd2, 16'h8000), 32'h0);
    commit("lui", mpc + 32'd4, 32'h80000000, 1'b1);
    apply(enc_i(6'h01, 5'd2, 5'd1, 16'h0005), 32'h0);
    commit("bgez_neg", mpc + 32'd4, mv0, 1'b1);
    apply(enc_i(6'h01, 5'd2, 5'd0, 16'hFFFE), 32'h0);
    commit("bltz_neg", mpc - 32'd4, mv0, 1'b1);
    apply(enc_r(5'd3, 5'd4, 5'd2, 5'd0, 6'h21), 32'h0);
    commit("addu", mpc + 32'd4, 32'h2468ACF0, 1'b1);
    apply(enc_i(6'h04, 5'd3, 5'd4, 16'h0003), 32'h0);
    commit("beq", mpc + 32'd16, mv0, 1'b1);
    apply(enc_i(6'h05, 5'd3, 5'd4, 16'h0003), 32'h0);
    commit("bne", mpc + 32'd4, mv0, 1'b1);
    apply(enc_r(5'd0, 5'd3, 5'd2, 5'd0, 6'h23), 32'h0);
    commit("subu", mpc + 32'd4, 32'hEDCBA988, 1'b1);
    apply(enc_r(5'd0, 5'd2, 5'd2, 5'd8, 6'h03), 32'h0);
    commit("sra", mpc + 32'd4, 32'hFFEDCBA9, 1'b1);
    apply(enc_r(5'd2, 5'd0, 5'd2, 5'd0, 6'h2A), 32'h0);
    commit("slt", mpc + 32'd4, 32'h1, 1'b1);
    apply(enc_r(5'd0, 5'd3, 5'd2, 5'd4, 6'h00), 32'h0);
    commit("sll", mpc + 32'd4, 32'h23456780, 1'b1);
    apply(enc_i(6'h0D, 5'd0, 5'd2, 16'hFFFF), 32'h0);
    commit("ori", mpc + 32'd4, 32'h0000FFFF, 1'b1);
    apply({6'h3F, 26'h3FFFFFF}, 32'h0);
    commit("unsup", mpc + 32'd4, mv0, 1'b1);

    // Stalled cycle: bus still decodes, nothing architectural moves
    clk_enable = 1'b0;
    apply(enc_i(6'h23, 5'd0, 5'd2, 16'h0000), 32'hCAFEF00D);
    check_eq("stall.dread", {31'h0, data_read}, 32'h1);
    commit("stall", mpc, mv0, 1'b1);
    clk_enable = 1'b1;

    reset = 1'b1;
    apply(enc_i(6'h23, 5'd0, 5'd2, 16'h0000), 32'h55555555);
    check_eq("rstmid.dread", {31'h0, data_read}, 32'h0);
    commit("rstmid", 32'hBFC00000, 32'h0, 1'b1);
    reset = 1'b0;

    apply(32'h0, 32'h0);
    commit("nop", 32'hBFC00004, 32'h0, 1'b1);
    apply({6'h03, 26'h0000010}, 32'h0);
    commit("jal", 32'hB0000040, 32'h0, 1'b1);
    apply(enc_r(5'd31, 5'd0, 5'd2, 5'd0, 6'h21), 32'h0);
    commit("link", mpc + 32'd4, 32'hBFC00008, 1'b1);
    apply(enc_i(6'h09, 5'd0, 5'd2, 16'hFFFF), 32'h0);
    commit("addiu", mpc + 32'd4, 32'hFFFFFFFF, 1'b1);
    apply(enc_i(6'h2B, 5'd0, 5'd2, 16'h0004), 32'h0);
    check_eq("sw.daddr",  data_address,        32'h4);
    check_eq("sw.wdata",  data_writedata,      32'hFFFFFFFF);
    check_eq("sw.dwrite", {31'h0, data_write}, 32'h1);
    check_eq("sw.dread",  {31'h0, data_read},  32'h0);
    commit("sw", mpc + 32'd4, mv0, 1'b1);

    apply(enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08), 32'h0);
    commit("jr0", 32'h0, mv0, 1'b0);
    apply(enc_i(6'h23, 5'd0, 5'd2, 16'h0000), 32'h77777777);
    check_eq("halt.dread", {31'h0, data_read}, 32'h0);
    commit("halted", 32'h0, mv0, 1'b0);

    reset = 1'b1;
    apply(32'h0, 32'h0);
    commit("rsthalt", 32'hBFC00000, 32'h0, 1'b1);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
